audio_mixer_n: RTL and testbench
================================

AUDIO_MIXER_N -- requirements
Module: audio_mixer_n

Interface
REQ-001 SHALL have parameter NUM_CH, default 6, number of mixed source channels (>=1).
REQ-002 SHALL have parameter SAMPLE_BITS, default 16, signed sample width.
REQ-003 SHALL have parameter VOLUME_BITS, default 8, unsigned gain width.
REQ-004 SHALL have parameter BUF_LEN, default 32, master buffer depth (power of 2); IW = $clog2(BUF_LEN).
REQ-005 SHALL have parameter LAG, default 1, write-behind distance from read index (0..BUF_LEN-1).
REQ-006 SHALL use one clock and an asynchronous, active-low reset, as the following two lines state.
REQ-007 mclk  in  1  audio master clock; sole clock.
REQ-008 rstn  in  1  asynchronous active-low reset.
REQ-009 pblrc  in  1  I2S frame clock, asynchronous to mclk; falling edge requests one mix.
REQ-010 samples  in  NUM_CH*SAMPLE_BITS  packed signed source samples; ch0 in LSBs.
REQ-011 ch_vol  in  NUM_CH*VOLUME_BITS  packed per-channel gain.
REQ-012 ch_mute  in  NUM_CH  per-channel mute; 1 forces that channel's contribution to 0.
REQ-013 master_vol  in  VOLUME_BITS  master gain.
REQ-014 rd_index  in  IW  output-driver read index.
REQ-015 rd_sample  out  SAMPLE_BITS  registered buffer[rd_index].
REQ-016 mix_valid  out  1  one-cycle pulse on each buffer write.
REQ-017 busy  out  1  high while a mix is in progress.
REQ-018 clip  out  1  sticky saturation flag.
REQ-019 overrun  out  1  sticky flag for a frame edge dropped while busy.
REQ-020 flag_clr  in  1  synchronous clear of clip and overrun.

Function
REQ-021 SHALL synchronise pblrc with two mclk flops and detect the falling edge on the synchronised signal.
REQ-022 SHALL implement FSM IDLE -> ACCUM -> SCALE -> WRITE -> IDLE; busy=1 in every state except IDLE.
REQ-023 IDLE: on a detected edge, SHALL snapshot samples, ch_vol, ch_mute and master_vol, and set wr_idx = (rd_index - LAG) mod BUF_LEN; it SHALL also clear acc to 0 and ch to 0.
REQ-024 ACCUM: each cycle SHALL add signed(sample[ch]) * unsigned(vol[ch]) (0 if muted) to acc; it SHALL leave after ch = NUM_CH-1, taking exactly NUM_CH cycles.
REQ-025 acc SHALL be SAMPLE_BITS+VOLUME_BITS+$clog2(NUM_CH)+1 bits signed and SHALL never overflow.
REQ-026 SCALE: SHALL compute ((acc >>> VOLUME_BITS) * master_vol) >>> VOLUME_BITS using arithmetic floor shifts at full width.
REQ-027 SCALE: SHALL saturate the result to [-2^(SAMPLE_BITS-1), 2^(SAMPLE_BITS-1)-1], setting clip when limiting occurs.
REQ-028 WRITE: SHALL write the saturated result to buffer[wr_idx] and pulse mix_valid for that one cycle.
REQ-029 Edge-to-write latency SHALL be NUM_CH+2 mclk cycles after edge detection.
REQ-030 A detected edge while busy SHALL be ignored and SHALL set overrun; the current mix SHALL complete unaltered.
REQ-031 Input changes after the snapshot SHALL NOT affect the current mix.
REQ-032 rd_sample SHALL equal buffer[rd_index] one cycle after rd_index is presented.
REQ-033 A simultaneous write and read of the same index SHALL return the old data.
REQ-034 flag_clr SHALL have priority over a same-cycle set of clip or overrun.
REQ-035 Gain SHALL be vol/2^VOLUME_BITS, so vol=0 yields 0 and there is no unity code.

Reset
REQ-036 rstn low SHALL asynchronously set the FSM to IDLE and clear acc, ch, all buffer entries, the sync flops, rd_sample, mix_valid, busy, clip and overrun.
REQ-037 Reset mid-mix SHALL abort the mix with no buffer write; the first edge after release SHALL start a fresh mix.

Verification (NUM_CH=6, SAMPLE_BITS=16, VOLUME_BITS=8, BUF_LEN=32, LAG=1)
REQ-038 Reset: assert rstn=0 mid-ACCUM -> busy=0, mix_valid=0, clip=0, overrun=0, every rd_index reads 0.
REQ-039 Single channel: ch0=1000, vol0=128, others muted, master=128, rd_index=5 -> buffer[4]=250, mix_valid pulsed NUM_CH+2 cycles after edge detection.
REQ-040 Saturation: all channels 30000, vol=255, master=255 -> 32767 written, clip=1; same test with -30000 -> -32768 written.
REQ-041 Mute and wrap: ch0=ch1=4000, vol=256-scale 128, ch1 muted, master=255, rd_index=0 -> buffer[31]=1992.
REQ-042 Overrun: second pblrc falling edge 3 cycles into ACCUM -> a single write, overrun=1; flag_clr -> clip=0, overrun=0.
REQ-043 Snapshot: change samples mid-ACCUM -> the written value matches the pre-edge inputs.

Source files
------------

// File: rtl/audio_mixer_n.sv
// N-channel audio mixer: on each pblrc falling edge, sums gain-scaled channels,
// applies master gain with saturation, and writes the result into a circular sample buffer.
module audio_mixer_n #(
  parameter int NUM_CH      = 6,
  parameter int SAMPLE_BITS = 16,
  parameter int VOLUME_BITS = 8,
  parameter int BUF_LEN     = 32,
  parameter int LAG         = 1,
  localparam int IW         = $clog2(BUF_LEN)
) (
  input  logic                          mclk,
  input  logic                          rstn,
  input  logic                          pblrc,
  input  logic [NUM_CH*SAMPLE_BITS-1:0] samples,
  input  logic [NUM_CH*VOLUME_BITS-1:0] ch_vol,
  input  logic [NUM_CH-1:0]             ch_mute,
  input  logic [VOLUME_BITS-1:0]        master_vol,
  input  logic [IW-1:0]                 rd_index,
  output logic [SAMPLE_BITS-1:0]        rd_sample,
  output logic                          mix_valid,
  output logic                          busy,
  output logic                          clip,
  output logic                          overrun,
  input  logic                          flag_clr,
  output logic [1:0]                    dbg_state
);

  localparam int CHW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int ACC_W = SAMPLE_BITS + VOLUME_BITS + $clog2(NUM_CH) + 1;
  localparam int SW    = ACC_W + VOLUME_BITS + 1;
  localparam logic [CHW-1:0] LAST_CH = CHW'(NUM_CH - 1);
  localparam logic signed [SW-1:0] MAX_S = {{(SW-SAMPLE_BITS+1){1'b0}}, {(SAMPLE_BITS-1){1'b1}}};
  localparam logic signed [SW-1:0] MIN_S = ~MAX_S;

  typedef enum logic [1:0] {IDLE, ACCUM, SCALE, WRITE} state_t;

  state_t                        state_q;
  logic                          sync1_q, sync2_q, sync3_q;
  logic [CHW-1:0]                ch_q;
  logic signed [ACC_W-1:0]       acc_q;
  logic [NUM_CH*SAMPLE_BITS-1:0] smp_q;
  logic [NUM_CH*VOLUME_BITS-1:0] vol_q;
  logic [NUM_CH-1:0]             mute_q;
  logic [VOLUME_BITS-1:0]        mvol_q;
  logic [IW-1:0]                 wr_idx_q;
  logic [SAMPLE_BITS-1:0]        res_q;
  logic                          mix_valid_q, busy_q, clip_q, overrun_q;
  logic [SAMPLE_BITS-1:0]        buf_q [BUF_LEN];
  logic [SAMPLE_BITS-1:0]        rd_sample_q;

  logic                          edge_det;
  logic signed [SAMPLE_BITS-1:0] smp_sel;
  logic [VOLUME_BITS-1:0]        vol_sel;
  logic signed [ACC_W-1:0]       smp_ext, vol_ext, prod, acc_d, acc_sh;
  logic signed [SW-1:0]          sh_ext, mv_ext, scaled;
  logic [SAMPLE_BITS-1:0]        res_d;
  logic                          sat_d;

  assign edge_det = sync3_q & ~sync2_q;

  always_comb begin
    smp_sel = smp_q[ch_q*SAMPLE_BITS +: SAMPLE_BITS];
    vol_sel = vol_q[ch_q*VOLUME_BITS +: VOLUME_BITS];
    smp_ext = {{(ACC_W-SAMPLE_BITS){smp_sel[SAMPLE_BITS-1]}}, smp_sel};
    vol_ext = {{(ACC_W-VOLUME_BITS){1'b0}}, vol_sel};
    prod    = mute_q[ch_q] ? '0 : smp_ext * vol_ext;
    acc_d   = acc_q + prod;
    // Floor shifts on signed values, widened so the master product cannot wrap.
    acc_sh  = acc_q >>> VOLUME_BITS;
    sh_ext  = {{(SW-ACC_W){acc_sh[ACC_W-1]}}, acc_sh};
    mv_ext  = {{(SW-VOLUME_BITS){1'b0}}, mvol_q};
    scaled  = (sh_ext * mv_ext) >>> VOLUME_BITS;
    sat_d   = 1'b0;
    res_d   = scaled[SAMPLE_BITS-1:0];
    if (scaled > MAX_S) begin
      res_d = MAX_S[SAMPLE_BITS-1:0];
      sat_d = 1'b1;
    end else if (scaled < MIN_S) begin
      res_d = MIN_S[SAMPLE_BITS-1:0];
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge mclk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync3_q     <= 1'b0;
      ch_q        <= '0;
      acc_q       <= '0;
      smp_q       <= '0;
      vol_q       <= '0;
      mute_q      <= '0;
      mvol_q      <= '0;
      wr_idx_q    <= '0;
      res_q       <= '0;
      mix_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      clip_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= pblrc;
      sync2_q     <= sync1_q;
      sync3_q     <= sync2_q;
      mix_valid_q <= 1'b0;
      if (flag_clr)                          overrun_q <= 1'b0;
      else if (edge_det && state_q != IDLE)  overrun_q <= 1'b1;
      if (flag_clr)                          clip_q <= 1'b0;
      else if (state_q == SCALE && sat_d)    clip_q <= 1'b1;
      case (state_q)
        IDLE: if (edge_det) begin
          smp_q    <= samples;
          vol_q    <= ch_vol;
          mute_q   <= ch_mute;
          mvol_q   <= master_vol;
          wr_idx_q <= rd_index - IW'(LAG);
          acc_q    <= '0;
          ch_q     <= '0;
          busy_q   <= 1'b1;
          state_q  <= ACCUM;
        end
        ACCUM: begin
          acc_q <= acc_d;
          if (ch_q == LAST_CH) state_q <= SCALE;
          else                 ch_q    <= ch_q + 1'b1;
        end
        SCALE: begin
          res_q       <= res_d;
          mix_valid_q <= 1'b1;
          state_q     <= WRITE;
        end
        WRITE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Nonblocking read of the pre-write contents gives read-before-write on a shared index.
  always_ff @(posedge mclk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < BUF_LEN; i++) buf_q[i] <= '0;
      rd_sample_q <= '0;
    end else begin
      if (state_q == WRITE) buf_q[wr_idx_q] <= res_q;
      rd_sample_q <= buf_q[rd_index];
    end
  end

  assign rd_sample = rd_sample_q;
  assign mix_valid = mix_valid_q;
  assign busy      = busy_q;
  assign clip      = clip_q;
  assign overrun   = overrun_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_audio_mixer_n.sv
// Directed bench for audio_mixer_n: single channel, mute/wrap, saturation, snapshot,
// overrun, flag clearing and mid-mix reset, with hand-computed expected values.
module tb_audio_mixer_n;

  localparam int NUM_CH = 6;
  localparam int SB     = 16;
  localparam int VB     = 8;
  localparam int BL     = 32;
  localparam int IW     = 5;
  // Falling pblrc reaches the detector on the 3rd edge; mix_valid is high NUM_CH+1 edges later.
  localparam int LAT    = 3 + NUM_CH + 1;

  logic                  mclk = 1'b0;
  logic                  rstn;
  logic                  pblrc;
  logic [NUM_CH*SB-1:0]  samples;
  logic [NUM_CH*VB-1:0]  ch_vol;
  logic [NUM_CH-1:0]     ch_mute;
  logic [VB-1:0]         master_vol;
  logic [IW-1:0]         rd_index;
  logic [SB-1:0]         rd_sample;
  logic                  mix_valid, busy, clip, overrun, flag_clr;
  logic [1:0]            dbg_state;

  int total = 0;
  int bad   = 0;

  audio_mixer_n #(
    .NUM_CH(NUM_CH), .SAMPLE_BITS(SB), .VOLUME_BITS(VB), .BUF_LEN(BL), .LAG(1)
  ) dut (
    .mclk(mclk), .rstn(rstn), .pblrc(pblrc), .samples(samples), .ch_vol(ch_vol),
    .ch_mute(ch_mute), .master_vol(master_vol), .rd_index(rd_index),
    .rd_sample(rd_sample), .mix_valid(mix_valid), .busy(busy), .clip(clip),
    .overrun(overrun), .flag_clr(flag_clr), .dbg_state(dbg_state)
  );

  always #5 mclk = ~mclk;

  function automatic logic [31:0] sx(input logic [SB-1:0] v);
    return {{(32-SB){v[SB-1]}}, v};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic set_all(input logic [SB-1:0] s, input logic [VB-1:0] v,
                         input logic [NUM_CH-1:0] m, input logic [VB-1:0] mv);
    for (int c = 0; c < NUM_CH; c++) begin
      samples[c*SB +: SB] = s;
      ch_vol[c*VB +: VB]  = v;
    end
    ch_mute    = m;
    master_vol = mv;
  endtask

  task automatic set_ch(input int c, input logic [SB-1:0] s, input logic [VB-1:0] v);
    samples[c*SB +: SB] = s;
    ch_vol[c*VB +: VB]  = v;
  endtask

  task automatic read_buf(input int idx, output logic [SB-1:0] val);
    @(negedge mclk);
    rd_index = IW'(idx);
    @(posedge mclk);
    @(negedge mclk);
    val = rd_sample;
  endtask

  task automatic clear_flags();
    @(negedge mclk);
    flag_clr = 1'b1;
    @(negedge mclk);
    flag_clr = 1'b0;
  endtask

  // action: 0 none, 1 change inputs mid-ACCUM, 2 second falling edge mid-ACCUM,
  // 3 point rd_index at the write slot during the write cycle.
  task automatic do_frame(input string tag, input int action, output logic [SB-1:0] rd_after);
    int   cyc;
    logic seen, b2, b3;
    cyc = 0; seen = 1'b0; b2 = 1'bx; b3 = 1'bx;
    @(negedge mclk);
    pblrc = 1'b0;
    while (!seen && cyc < 40) begin
      @(posedge mclk);
      @(negedge mclk);
      cyc++;
      if (cyc == 2) b2 = busy;
      if (cyc == 3) b3 = busy;
      if (action == 1 && cyc == 5) set_all(16'h7FFF, 8'hFF, '0, 8'hFF);
      if (action == 2 && cyc == 3) pblrc = 1'b1;
      if (action == 2 && cyc == 4) pblrc = 1'b0;
      if (mix_valid === 1'b1) seen = 1'b1;
    end
    check({tag, "_latency"}, cyc, LAT);
    check({tag, "_busy_pre"}, {31'd0, b2}, 0);
    check({tag, "_busy_det"}, {31'd0, b3}, 1);
    if (action == 3) rd_index = rd_index - 1'b1;
    @(posedge mclk);
    @(negedge mclk);
    rd_after = rd_sample;
    check({tag, "_valid_pulse"}, {31'd0, mix_valid}, 0);
    check({tag, "_busy_done"}, {31'd0, busy}, 0);
    pblrc = 1'b1;
    repeat (4) @(negedge mclk);
  endtask

  initial begin
    logic [SB-1:0] v, ra;
    int            pulses;

    rstn = 1'b0; pblrc = 1'b1; flag_clr = 1'b0; rd_index = '0;
    set_all('0, '0, '0, '0);
    repeat (3) @(negedge mclk);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_valid", {31'd0, mix_valid}, 0);
    check("rst_clip", {31'd0, clip}, 0);
    check("rst_overrun", {31'd0, overrun}, 0);
    check("rst_rd_sample", sx(rd_sample), 0);
    rstn = 1'b1;
    repeat (4) @(negedge mclk);

    // 1000*128>>8 = 500, 500*128>>8 = 250, lands at 5-1.
    set_all('0, '0, 6'b111110, 8'd128);
    set_ch(0, 16'd1000, 8'd128);
    rd_index = 5'd5;
    do_frame("single", 0, ra);
    read_buf(4, v);  check("single_buf4", sx(v), 250);
    read_buf(5, v);  check("single_buf5", sx(v), 0);

    // ch1 muted: 4000*128>>8 = 2000, 2000*255>>8 = 1992, index 0-1 wraps to 31.
    set_all('0, '0, 6'b000010, 8'd255);
    set_ch(0, 16'd4000, 8'd128);
    set_ch(1, 16'd4000, 8'd128);
    rd_index = 5'd0;
    do_frame("wrap", 0, ra);
    read_buf(31, v); check("wrap_buf31", sx(v), 1992);
    check("wrap_clip", {31'd0, clip}, 0);

    set_all('0, '0, 6'b111110, 8'd128);
    set_ch(0, 16'd1000, 8'd128);
    rd_index = 5'd25;
    do_frame("snap", 1, ra);
    read_buf(24, v); check("snap_buf24", sx(v), 250);
    check("snap_clip", {31'd0, clip}, 0);

    // 6*30000*255>>8 = 179296, *255>>8 = 178595 -> clipped.
    set_all(16'd30000, 8'd255, '0, 8'd255);
    rd_index = 5'd10;
    do_frame("satp", 0, ra);
    read_buf(9, v);  check("satp_buf9", sx(v), 32767);
    check("satp_clip", {31'd0, clip}, 1);
    clear_flags();
    check("satp_clip_clr", {31'd0, clip}, 0);

    set_all(16'h8AD0, 8'd255, '0, 8'd255);
    rd_index = 5'd11;
    do_frame("satn", 0, ra);
    read_buf(10, v); check("satn_buf10", sx(v), -32768);
    check("satn_clip", {31'd0, clip}, 1);

    // Reset in the middle of ACCUM with clip still set.
    set_all('0, '0, 6'b111110, 8'd128);
    set_ch(0, 16'd1000, 8'd128);
    rd_index = 5'd8;
    @(negedge mclk);
    pblrc = 1'b0;
    repeat (5) @(negedge mclk);
    rstn = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 0);
    check("mid_rst_valid", {31'd0, mix_valid}, 0);
    check("mid_rst_clip", {31'd0, clip}, 0);
    check("mid_rst_overrun", {31'd0, overrun}, 0);
    repeat (2) @(negedge mclk);
    rstn = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge mclk);
      if (mix_valid === 1'b1) pulses++;
    end
    check("mid_rst_no_write", pulses, 0);
    check("mid_rst_idle", {31'd0, busy}, 0);
    pblrc = 1'b1;
    repeat (4) @(negedge mclk);
    for (int i = 0; i < BL; i++) begin
      read_buf(i, v);
      check($sformatf("mid_rst_buf%0d", i), sx(v), 0);
    end

    // Fresh mix after reset; reading slot 4 during its write cycle returns the old 0.
    rd_index = 5'd5;
    do_frame("fresh", 3, ra);
    check("fresh_rd_old", sx(ra), 0);
    read_buf(4, v);  check("fresh_buf4", sx(v), 250);

    rd_index = 5'd20;
    do_frame("ovr", 2, ra);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge mclk);
      if (mix_valid === 1'b1) pulses++;
    end
    check("ovr_single_write", pulses, 0);
    read_buf(19, v); check("ovr_buf19", sx(v), 250);
    check("ovr_flag", {31'd0, overrun}, 1);
    clear_flags();
    check("ovr_flag_clr", {31'd0, overrun}, 0);
    check("ovr_clip_clr", {31'd0, clip}, 0);

    // flag_clr held through a saturating mix wins over the clip set.
    set_all(16'h8AD0, 8'd255, '0, 8'd255);
    rd_index = 5'd14;
    @(negedge mclk);
    flag_clr = 1'b1;
    do_frame("prio", 0, ra);
    check("prio_clip", {31'd0, clip}, 0);
    flag_clr = 1'b0;
    read_buf(13, v); check("prio_buf13", sx(v), -32768);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
